// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a built-in 2-entry skid buffer.
// Registered valid/ready handshake on both sides, plus a flush that kills every held beat.

module pipe_stage_skid_chk (
  input logic       clk,
  input logic       rst,
  input logic [1:0] occupancy
);

  // occupancy is the state encoding, and the encoding never uses 3
  assert property (@(posedge clk) disable iff (rst) occupancy != 2'd3)
    else $error("occupancy reached 3");

endmodule

module pipe_stage_skid #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]    state_r;
  logic [1:0]    next_state_s;
  logic [DW-1:0] main_r;
  logic [DW-1:0] skid_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          acc_s;
  logic          emit_s;
  logic          load_main_in_s;
  logic          load_main_skid_s;
  logic          load_skid_s;

  assign acc_s  = in_valid & in_ready_r;
  assign emit_s = out_valid_r & out_ready;

  // Next-state and register-load selection
  always_comb begin
    next_state_s     = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      next_state_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (acc_s) begin
            next_state_s   = BUSY;
            load_main_in_s = 1'b1;
          end else begin
            next_state_s = EMPTY;
          end
        end
        BUSY: begin
          if (acc_s && emit_s) begin
            next_state_s   = BUSY;
            load_main_in_s = 1'b1;
          end else if (acc_s) begin
            next_state_s = FULL;
            load_skid_s  = 1'b1;
          end else if (emit_s) begin
            next_state_s = EMPTY;
          end else begin
            next_state_s = BUSY;
          end
        end
        FULL: begin
          // in_ready is low here, so the only move is draining the skid into main
          if (emit_s) begin
            next_state_s     = BUSY;
            load_main_skid_s = 1'b1;
          end else begin
            next_state_s = FULL;
          end
        end
        default: begin
          next_state_s = EMPTY;
        end
      endcase
    end
  end

  // State, handshake outputs and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      main_r      <= RST_VAL;
      skid_r      <= RST_VAL;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s != FULL);
      out_valid_r <= (next_state_s != EMPTY);
      if (load_main_in_s) begin
        main_r <= in_data;
      end else if (load_main_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= in_data;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = state_r;

  pipe_stage_skid_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .occupancy (state_r)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random testbench for pipe_stage_skid (DW=32, RST_VAL=0).
// Outputs are sampled 1 time unit after each rising edge, and inputs are changed there.

module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int vectors = 0;
  int miscompares = 0;

  pipe_stage_skid #(.DW(32), .RST_VAL(32'd0)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    step();
    rst = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    vectors++; if (out_data !== 32'd0) begin miscompares++; $display("FAIL reset_out_data got %0h want 0", out_data); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
      vectors++; if (out_data !== 32'(i) || out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_data beat %0d got %0h/v%0b want %0h/v1", i, out_data, out_valid, i); end
      vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("FAIL stream_occ beat %0d got %0d want 1", i, occupancy); end
    end
    in_valid = 1'b0;
    step();
    vectors++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain got occ %0d v%0b want occ 0 v0", occupancy, out_valid); end
  endtask

  task automatic test_stall_skid();
    in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b1;
    step();
    vectors++; if (out_data !== 32'hA || out_valid !== 1'b1) begin miscompares++; $display("FAIL skid_first got %0h want a", out_data); end
    out_ready = 1'b0; in_data = 32'hB;
    step();
    vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("FAIL skid_full_occ got %0d want 2", occupancy); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_full_ready got %0b want 0", in_ready); end
    vectors++; if (out_data !== 32'hA) begin miscompares++; $display("FAIL skid_hold_a got %0h want a", out_data); end
    in_data = 32'hC;
    step();
    vectors++; if (out_data !== 32'hA || out_valid !== 1'b1 || occupancy !== 2'd2) begin miscompares++; $display("FAIL skid_stall_stable got %0h/v%0b/occ%0d want a/v1/occ2", out_data, out_valid, occupancy); end
    out_ready = 1'b1;
    step();
    vectors++; if (out_data !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_emit_b got %0h/occ%0d/r%0b want b/occ1/r1", out_data, occupancy, in_ready); end
    step();
    vectors++; if (out_data !== 32'hC || out_valid !== 1'b1) begin miscompares++; $display("FAIL skid_emit_c got %0h want c", out_data); end
    in_valid = 1'b0;
    step();
    vectors++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL skid_drain got occ %0d want 0", occupancy); end
  endtask

  task automatic test_flush_full();
    in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;
    step();
    in_data = 32'h22;
    step();
    vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("FAIL flush_setup_occ got %0d want 2", occupancy); end
    flush = 1'b1; in_data = 32'h33;
    step();
    flush = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_empty got v%0b occ%0d r%0b want v0 occ0 r1", out_valid, occupancy, in_ready); end
    vectors++; if (out_data !== 32'h11) begin miscompares++; $display("FAIL flush_data_hold got %0h want 11", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_ghost cycle %0d got v%0b data %0h want v0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1; in_data = 32'h44; out_ready = 1'b0;
    step();
    vectors++; if (out_data !== 32'h44 || occupancy !== 2'd1) begin miscompares++; $display("FAIL rstmid_setup got %0h occ%0d want 44 occ1", out_data, occupancy); end
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    vectors++; if (out_data !== 32'd0 || out_valid !== 1'b0 || occupancy !== 2'd0) begin miscompares++; $display("FAIL rstmid_clear got %0h/v%0b/occ%0d want 0/v0/occ0", out_data, out_valid, occupancy); end
    in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (out_data !== 32'h5 || out_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_first got %0h/v%0b want 5/v1", out_data, out_valid); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_drain got v%0b want v0", out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] nxt;
    logic [31:0] prev_data;
    logic        pending;
    logic        acc;
    logic        emit;
    logic        stall;
    logic        fl;
    nxt = 32'h1000; pending = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if (in_valid) begin
          in_data = nxt; nxt = nxt + 32'd1; pending = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 63) == 0);
      acc = in_valid & in_ready;
      emit = out_valid & out_ready;
      stall = out_valid & ~out_ready;
      fl = flush;
      prev_data = out_data;
      if (fl) begin
        q.delete(); pending = 1'b0;
      end else begin
        if (emit) void'(q.pop_front());
        if (acc) begin q.push_back(in_data); pending = 1'b0; end
      end
      step();
      vectors++; if (occupancy !== 2'(q.size()) || out_valid !== (q.size() != 0) || in_ready !== (q.size() != 2)) begin miscompares++; $display("FAIL rand_ctrl cycle %0d got occ%0d v%0b r%0b want occ%0d", c, occupancy, out_valid, in_ready, q.size()); end
      if (q.size() != 0) begin
        vectors++; if (out_data !== q[0]) begin miscompares++; $display("FAIL rand_order cycle %0d got %0h want %0h", c, out_data, q[0]); end
      end
      if (stall && !fl) begin
        vectors++; if (out_data !== prev_data || out_valid !== 1'b1) begin miscompares++; $display("FAIL rand_stall cycle %0d got %0h/v%0b want %0h/v1", c, out_data, out_valid, prev_data); end
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush_full();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
